// File: rtl/cache_lru_wb_if.sv
// Requester and backing-RAM signal bundle for cache_lru_wb.
// slave is the cache side, master is the requester/RAM side.
interface cache_lru_wb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              flush;
  logic              ready;
  logic              valid;
  logic              hit;
  logic [DATA_W-1:0] q;
  logic              flush_done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req, wren, address, data, flush, mem_q,
    output ready, valid, hit, q, flush_done,
    output mem_address, mem_data, mem_wren
  );

  modport master (
    output req, wren, address, data, flush, mem_q,
    input  ready, valid, hit, q, flush_done,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/cache_lru_wb.sv
// Fully-associative write-back cache, true-LRU by per-way age,
// with flush of all dirty lines to a synchronous-read backing RAM.
module cache_lru_wb #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int WAYS    = 4,
  parameter int MEM_LAT = 2
) (
  input logic           clock,
  input logic           resetn,
  cache_lru_wb_if.slave bus
);
  localparam int AW = $clog2(WAYS);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef logic [WAYS-1:0][AW-1:0] age_t;
  typedef enum logic [1:0] {
    IDLE, WB, FILL, FLUSH
  } state_t;

  state_t                      state;
  logic [WAYS-1:0]             lv;
  logic [WAYS-1:0]             ld;
  logic [WAYS-1:0][ADDR_W-1:0] tag;
  logic [WAYS-1:0][DATA_W-1:0] dat;
  age_t                        age;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;
  logic [AW-1:0]     vic;
  logic [CW-1:0]     cnt;
  logic [AW:0]       fcnt;

  logic              valid_r;
  logic              hit_r;
  logic [DATA_W-1:0] q_r;
  logic              fdone_r;
  logic [ADDR_W-1:0] maddr_r;
  logic [DATA_W-1:0] mdata_r;
  logic              mwren_r;

  logic          hit_any;
  logic          inv_any;
  logic          vdirty;
  logic [AW-1:0] hway;
  logic [AW-1:0] iway;
  logic [AW-1:0] oway;
  logic [AW-1:0] vway;

  assign bus.ready       = (state == IDLE);
  assign bus.valid       = valid_r;
  assign bus.hit         = hit_r;
  assign bus.q           = q_r;
  assign bus.flush_done  = fdone_r;
  assign bus.mem_address = maddr_r;
  assign bus.mem_data    = mdata_r;
  assign bus.mem_wren    = mwren_r;

  // Younger-than-w ways age by one; w becomes the most recent.
  function automatic age_t touch(
    input age_t          a,
    input logic [AW-1:0] w
  );
    age_t r;
    r = a;
    for (int j = 0; j < WAYS; j++)
      if (a[j] < a[w]) r[j] = a[j] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  always_comb begin
    hit_any = 1'b0;
    hway    = '0;
    inv_any = 1'b0;
    iway    = '0;
    oway    = '0;
    for (int j = 0; j < WAYS; j++) begin
      if (lv[j] && tag[j] == bus.address) begin
        hit_any = 1'b1;
        hway    = AW'(j);
      end
      if (age[j] == AW'(WAYS - 1)) oway = AW'(j);
    end
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (!lv[j]) begin
        inv_any = 1'b1;
        iway    = AW'(j);
      end
    end
    vway   = inv_any ? iway : oway;
    vdirty = lv[vway] & ld[vway];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      lv      <= '0;
      ld      <= '0;
      tag     <= '0;
      dat     <= '0;
      for (int i = 0; i < WAYS; i++)
        age[i] <= AW'(i);
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
      vic     <= '0;
      cnt     <= '0;
      fcnt    <= '0;
      valid_r <= 1'b0;
      hit_r   <= 1'b0;
      q_r     <= '0;
      fdone_r <= 1'b0;
      maddr_r <= '0;
      mdata_r <= '0;
      mwren_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      fdone_r <= 1'b0;
      mwren_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.flush) begin
            state <= FLUSH;
            fcnt  <= 1;
            if (lv[0] && ld[0]) begin
              mwren_r <= 1'b1;
              maddr_r <= tag[0];
              mdata_r <= dat[0];
              ld[0]   <= 1'b0;
            end
          end else if (bus.req) begin
            r_addr <= bus.address;
            r_data <= bus.data;
            r_wren <= bus.wren;
            if (hit_any) begin
              valid_r <= 1'b1;
              hit_r   <= 1'b1;
              age     <= touch(age, hway);
              if (bus.wren) begin
                dat[hway] <= bus.data;
                ld[hway]  <= 1'b1;
                q_r       <= bus.data;
              end else begin
                q_r <= dat[hway];
              end
            end else begin
              vic <= vway;
              if (vdirty) begin
                state    <= WB;
                mwren_r  <= 1'b1;
                maddr_r  <= tag[vway];
                mdata_r  <= dat[vway];
                ld[vway] <= 1'b0;
              end else if (bus.wren) begin
                lv[vway]  <= 1'b1;
                ld[vway]  <= 1'b1;
                tag[vway] <= bus.address;
                dat[vway] <= bus.data;
                age       <= touch(age, vway);
                valid_r   <= 1'b1;
                hit_r     <= 1'b0;
                q_r       <= bus.data;
              end else begin
                state   <= FILL;
                maddr_r <= bus.address;
                cnt     <= '0;
              end
            end
          end
        end
        WB: begin
          if (r_wren) begin
            state    <= IDLE;
            lv[vic]  <= 1'b1;
            ld[vic]  <= 1'b1;
            tag[vic] <= r_addr;
            dat[vic] <= r_data;
            age      <= touch(age, vic);
            valid_r  <= 1'b1;
            hit_r    <= 1'b0;
            q_r      <= r_data;
          end else begin
            state   <= FILL;
            maddr_r <= r_addr;
            cnt     <= '0;
          end
        end
        FILL: begin
          if (cnt == CW'(MEM_LAT)) begin
            state    <= IDLE;
            lv[vic]  <= 1'b1;
            ld[vic]  <= 1'b0;
            tag[vic] <= r_addr;
            dat[vic] <= bus.mem_q;
            age      <= touch(age, vic);
            valid_r  <= 1'b1;
            hit_r    <= 1'b0;
            q_r      <= bus.mem_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt == (AW+1)'(WAYS)) begin
            state   <= IDLE;
            fdone_r <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
            if (lv[fcnt[AW-1:0]] && ld[fcnt[AW-1:0]]) begin
              mwren_r            <= 1'b1;
              maddr_r            <= tag[fcnt[AW-1:0]];
              mdata_r            <= dat[fcnt[AW-1:0]];
              ld[fcnt[AW-1:0]]   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_lru_wb.sv
// Bench for cache_lru_wb: recency-list reference model, per-cycle
// compare of every output, directed literal cases, random traffic.
module tb_cache_lru_wb;
  localparam int AW_ = 5;
  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int LAT = 2;
  localparam int NS  = 8192;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  cache_lru_wb_if #(.ADDR_W(AW_), .DATA_W(DW)) bus ();

  cache_lru_wb #(
    .ADDR_W(AW_), .DATA_W(DW), .WAYS(NW), .MEM_LAT(LAT)
  ) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  // backing RAM with LAT-cycle read pipeline
  logic [DW-1:0] ram [32];
  logic [DW-1:0] pipe [LAT];
  assign bus.mem_q = pipe[LAT-1];
  initial begin
    for (int a = 0; a < 32; a++) ram[a] = DW'(a + 'h40);
    for (int k = 0; k < LAT; k++) pipe[k] = '0;
    forever begin
      @(posedge clock);
      pipe[0] <= ram[bus.mem_address];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // expectations per output slot (slot n = cycle after edge n-1)
  bit e_busy [NS];
  bit e_valid [NS];
  bit e_hit [NS];
  int e_q [NS];
  bit e_wren [NS];
  int e_ma [NS];
  int e_md [NS];
  bit e_fill [NS];
  int e_fa [NS];
  bit e_fdone [NS];

  // reference model: lines plus recency list (front = most recent)
  bit mv [NW];
  bit md [NW];
  int mt [NW];
  int mdat [NW];
  int ord [$];
  int ref_mem [32];
  int model_free = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int last_q, last_hit, last_vslot, vcnt, wbcnt, fdone_slot;
  int wbq_a [$];
  int wbq_d [$];
  int acc_slot;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s slot %0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic touch_m(int w);
    for (int i = 0; i < ord.size(); i++)
      if (ord[i] == w) begin
        ord.delete(i);
        break;
      end
    ord.push_front(w);
  endtask

  task automatic install(int w, int a, int d, bit dirty);
    mv[w] = 1; md[w] = dirty; mt[w] = a; mdat[w] = d;
    touch_m(w);
  endtask

  task automatic set_wb(int s, int w);
    e_wren[s] = 1; e_ma[s] = mt[w]; e_md[s] = mdat[w];
    ref_mem[mt[w]] = mdat[w];
    md[w] = 0;
  endtask

  task automatic set_valid(int s, bit h, int d);
    e_valid[s] = 1; e_hit[s] = h; e_q[s] = d;
    model_free = s;
  endtask

  task automatic model_issue(bit rq, bit fl, bit wr,
                             int a, int d, int s);
    int w;
    int t;
    if (fl) begin
      for (int i = 0; i < NW; i++) begin
        e_busy[s+1+i] = 1;
        if (mv[i] && md[i]) set_wb(s + 1 + i, i);
      end
      e_fdone[s+NW+1] = 1;
      model_free = s + NW + 1;
      return;
    end
    if (!rq) return;
    w = -1;
    for (int i = 0; i < NW; i++)
      if (mv[i] && mt[i] == a) w = i;
    if (w >= 0) begin
      if (wr) begin
        mdat[w] = d; md[w] = 1;
      end
      touch_m(w);
      set_valid(s + 1, 1, mdat[w]);
      return;
    end
    for (int i = NW - 1; i >= 0; i--)
      if (!mv[i]) w = i;
    if (w < 0) w = ord[ord.size()-1];
    t = s;
    if (mv[w] && md[w]) begin
      set_wb(s + 1, w);
      e_busy[s+1] = 1;
      t = s + 1;
    end
    if (wr) begin
      install(w, a, d, 1);
      set_valid(t + 1, 0, d);
    end else begin
      for (int k = 1; k <= LAT + 1; k++) begin
        e_busy[t+k] = 1; e_fill[t+k] = 1; e_fa[t+k] = a;
      end
      install(w, a, ref_mem[a], 0);
      set_valid(t + LAT + 2, 0, ref_mem[a]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      mv[i] = 0; md[i] = 0;
    end
    ord = {0, 1, 2, 3};
    for (int k = cyc + 1; k < cyc + 40 && k < NS; k++) begin
      e_busy[k] = 0; e_valid[k] = 0; e_wren[k] = 0;
      e_fill[k] = 0; e_fdone[k] = 0;
    end
  endtask

  // per-cycle compare against the model
  initial begin
    bit [NW-1:0] seen;
    int s;
    forever begin
      @(negedge clock);
      s = cyc;
      if (s < NS) begin
        chk("ready", bus.ready, !e_busy[s]);
        chk("valid", bus.valid, e_valid[s]);
        if (e_valid[s]) begin
          chk("hit", bus.hit, e_hit[s]);
          chk("q", bus.q, e_q[s]);
        end
        chk("mem_wren", bus.mem_wren, e_wren[s]);
        if (e_wren[s]) begin
          chk("wb_addr", bus.mem_address, e_ma[s]);
          chk("wb_data", bus.mem_data, e_md[s]);
        end
        if (e_fill[s]) chk("fill_addr", bus.mem_address, e_fa[s]);
        chk("flush_done", bus.flush_done, e_fdone[s]);
        seen = '0;
        for (int i = 0; i < NW; i++) seen[dut.age[i]] = 1'b1;
        chk("age_perm", seen, {NW{1'b1}});
      end
      if (bus.valid === 1'b1) begin
        last_q = bus.q; last_hit = bus.hit;
        last_vslot = s; vcnt++;
      end
      if (bus.mem_wren === 1'b1) begin
        wbcnt++;
        wbq_a.push_back(bus.mem_address);
        wbq_d.push_back(bus.mem_data);
      end
      if (bus.flush_done === 1'b1) fdone_slot = s;
    end
  end

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_free();
    int g = 0;
    while (cyc < model_free && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) chk("ready_timeout", 0, 1);
  endtask

  // kind: 0 read, 1 write, 2 flush, 3 write+flush together
  task automatic op(int kind, int a, int d, bit wait_done);
    wait_free();
    bus.req = (kind != 2);
    bus.flush = (kind >= 2);
    bus.wren = (kind == 1 || kind == 3);
    bus.address = AW_'(a);
    bus.data = DW'(d);
    acc_slot = cyc;
    model_issue(bus.req, bus.flush, bus.wren, a, d, cyc);
    step();
    bus.req = 0;
    bus.flush = 0;
    if (wait_done) wait_free();
  endtask

  task automatic do_reset();
    resetn = 0;
    model_reset();
    step();
    step();
    resetn = 1;
    model_free = cyc;
  endtask

  initial begin
    int w0, v0, r;
    bus.req = 0; bus.flush = 0; bus.wren = 0;
    bus.address = '0; bus.data = '0;
    for (int a = 0; a < 32; a++) ref_mem[a] = a + 'h40;
    model_reset();
    step();
    chk("rst_ready", bus.ready, 1);
    chk("rst_valid", bus.valid, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_fdone", bus.flush_done, 0);
    chk("rst_mwren", bus.mem_wren, 0);
    chk("rst_maddr", bus.mem_address, 0);
    chk("rst_mdata", bus.mem_data, 0);
    step();
    resetn = 1;
    model_free = cyc;

    w0 = wbcnt;
    op(0, 3, 0, 1);
    chk("rd3_lat", last_vslot - acc_slot - 1, 3);
    chk("rd3_q", last_q, 'h43);
    chk("rd3_hit", last_hit, 0);
    op(0, 3, 0, 1);
    chk("rd3b_lat", last_vslot - acc_slot - 1, 0);
    chk("rd3b_hit", last_hit, 1);
    chk("rd3b_q", last_q, 'h43);
    chk("rd3_nowb", wbcnt - w0, 0);

    for (int a = 0; a <= 4; a++) op(0, a, 0, 1);
    op(0, 0, 0, 1);
    chk("evict0_hit", last_hit, 0);
    for (int a = 2; a <= 4; a++) begin
      op(0, a, 0, 1);
      chk("lru_keep_hit", last_hit, 1);
    end

    do_reset();
    for (int a = 0; a <= 3; a++) op(0, a, 0, 1);
    op(1, 1, 'h11, 1);
    chk("wr1_hit", last_hit, 1);
    chk("wr1_q", last_q, 'h11);
    op(0, 1, 0, 1);
    chk("rd1_q", last_q, 'h11);
    w0 = wbcnt;
    for (int a = 4; a <= 7; a++) op(0, a, 0, 1);
    chk("evict_wb_cnt", wbcnt - w0, 1);
    chk("evict_wb_addr", wbq_a[wbq_a.size()-1], 1);
    chk("evict_wb_data", wbq_d[wbq_d.size()-1], 'h11);
    op(0, 1, 0, 1);
    chk("refill1_hit", last_hit, 0);
    chk("refill1_q", last_q, 'h11);

    op(0, 8, 0, 0);
    step();
    resetn = 0;
    #1;
    chk("arst_ready", bus.ready, 1);
    chk("arst_valid", bus.valid, 0);
    chk("arst_mwren", bus.mem_wren, 0);
    model_reset();
    step();
    resetn = 1;
    model_free = cyc;
    op(0, 8, 0, 1);
    chk("after_rst_hit", last_hit, 0);
    w0 = wbcnt;
    op(1, 9, 'h9C, 1);
    chk("wm_lat", last_vslot - acc_slot - 1, 0);
    chk("wm_hit", last_hit, 0);
    chk("wm_q", last_q, 'h9C);
    chk("wm_nowb", wbcnt - w0, 0);

    do_reset();
    op(1, 20, 'h21, 1);
    op(0, 21, 0, 1);
    op(1, 22, 'h22, 1);
    op(0, 23, 0, 1);
    w0 = wbcnt;
    op(2, 0, 0, 1);
    chk("fl_cnt", wbcnt - w0, 2);
    chk("fl_a0", wbq_a[wbq_a.size()-2], 20);
    chk("fl_d0", wbq_d[wbq_d.size()-2], 'h21);
    chk("fl_a1", wbq_a[wbq_a.size()-1], 22);
    chk("fl_d1", wbq_d[wbq_d.size()-1], 'h22);
    chk("fl_done_lat", fdone_slot - acc_slot - 1, NW);
    w0 = wbcnt;
    op(2, 0, 0, 1);
    chk("fl2_cnt", wbcnt - w0, 0);
    chk("fl2_done_lat", fdone_slot - acc_slot - 1, NW);
    v0 = vcnt;
    op(3, 30, 'h5A, 1);
    chk("fl_req_novalid", vcnt - v0, 0);
    chk("fl_req_done_lat", fdone_slot - acc_slot - 1, NW);

    repeat (3000) begin
      if (cyc >= model_free) begin
        r = $urandom_range(0, 99);
        bus.req = (r < 80) || (r >= 90 && r < 95);
        bus.flush = (r >= 85 && r < 95);
        bus.wren = (r >= 45);
        bus.address = AW_'($urandom_range(0, 11));
        bus.data = DW'($urandom_range(0, 255));
        model_issue(bus.req, bus.flush, bus.wren,
                    bus.address, bus.data, cyc);
      end else begin
        bus.req = 1'($urandom);
        bus.flush = ($urandom_range(0, 7) == 0);
        bus.wren = 1'($urandom);
        bus.address = AW_'($urandom_range(0, 31));
        bus.data = DW'($urandom);
      end
      step();
    end
    bus.req = 0;
    bus.flush = 0;
    wait_free();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_lru_wb.md
# cache_lru_wb

Parametrised fully-associative write-back cache with true-LRU replacement between a requester and a synchronous-read backing RAM. It has WAYS lines, configurable address/data widths and memory read latency, an explicit req/ready handshake, a hit indicator, and a flush operation that writes back every dirty line. It sits between the datapath and the single-port backing RAM, replacing the fixed 4-line cache front end.

## Interface
- ADDR_W, 5, address width.
- DATA_W, 8, data width.
- WAYS, 4, line count; power of two, >= 2. Age width AW = log2(WAYS).
- MEM_LAT, 2, cycles from mem_address sampled by the RAM to mem_q valid; >= 1.

- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; accepted when req && ready at a clock edge.
- wren  in  1  1 = write, 0 = read; sampled at accept.
- address  in  ADDR_W  request address; sampled at accept.
- data  in  DATA_W  write data; sampled at accept.
- flush  in  1  flush strobe; accepted when flush && ready.
- ready  out  1  block idle and accepting.
- valid  out  1  one-cycle pulse, request complete.
- hit  out  1  qualifies valid: 1 = hit.
- q  out  DATA_W  read data, or written data for writes; held until next valid.
- flush_done  out  1  one-cycle pulse, flush complete.
- mem_address  out  ADDR_W  backing RAM address.
- mem_data  out  DATA_W  backing RAM write data.
- mem_wren  out  1  backing RAM write enable; one cycle per write-back.
- mem_q  in  DATA_W  backing RAM read data.

## Operation
- Each line holds valid, dirty, tag[ADDR_W], data[DATA_W] and age[AW].
- Reset state: all lines invalid and clean; way i has age i.
- Ages always form a permutation of 0..WAYS-1.
- Touch way w with age a: every way with age < a increments, then w's age becomes 0. Hits, write-allocates and fills all touch.
- States: IDLE, WB, FILL, FLUSH. ready = (state == IDLE).
- IDLE, accepted flush: go to FLUSH. If req is also high, flush wins and req is dropped.
- IDLE, accepted req, hit: update the line and touch it. A write stores data and sets dirty. q = line data. Stay in IDLE.
- IDLE, accepted req, miss: choose a victim. It is the lowest-index invalid way; if none is invalid, the way with age WAYS-1.
  - Victim dirty: go to WB.
  - Victim clean, write: install tag/data with dirty=1, touch, stay in IDLE (no memory access).
  - Victim clean, read: go to FILL.
- WB: one cycle. mem_wren=1, mem_address = victim tag, mem_data = victim data; clear victim dirty.
  - Then a write installs as above and returns to IDLE.
  - A read goes to FILL.
- FILL: mem_address = request address, held stable, mem_wren=0. Wait MEM_LAT cycles, then capture mem_q. Install with dirty=0, touch, q = mem_q, return to IDLE.
- FLUSH: scan ways 0..WAYS-1, one per cycle. A valid dirty way drives mem_wren=1 with its tag/data and clears dirty.
  - Lines stay valid; ages are unchanged.
  - After way WAYS-1: flush_done pulses and the block returns to IDLE.
- req/flush while ready=0 are ignored, not queued. Inputs may change freely after accept.

## Timing
- Reset values: ready=1, valid=0, hit=0, q=0, flush_done=0, mem_wren=0, mem_address=0, mem_data=0, state IDLE.
- Reset asserted mid-operation aborts immediately (async). No partial write-back completes after reset.
- Request accepted at edge E0; valid/hit/q update after:
  - hit: E0 (latency 1);
  - clean write miss: E0;
  - dirty write miss: E0+1;
  - clean read miss: E0+MEM_LAT+1;
  - dirty read miss: E0+MEM_LAT+2.
- ready stays 1 through hits and clean write misses, so back-to-back accepts are possible at one per cycle.
- ready returns to 1 in the same cycle valid pulses, and a new req may be accepted then.
- Flush accepted at E0: way i is processed in the cycle after E0+i. flush_done is high in the cycle after E0+WAYS, together with ready=1.
- mem_wren is never high outside WB/FLUSH. At most one write-back per miss.

## Test plan
Configuration: WAYS=4, ADDR_W=5, DATA_W=8, MEM_LAT=2. RAM model preloaded with mem[a] = a+0x40.
- Read 3 after reset -> valid 3 cycles after accept, q=0x43, hit=0, no mem_wren. Read 3 again -> valid next cycle, hit=1, q=0x43.
- Reads 0,1,2,3 then 4 -> read 4 misses and replaces line of 0. Read 0 -> hit=0. Reads 2,3,4 -> hit=1. Ages remain a permutation after every access.
- Fill 0..3, write 0x11 to 1 (hit, q=0x11), read 1 -> q=0x11. Then reads 4,5,6,7 -> one mem_wren pulse with mem_address=1, mem_data=0x11 before the fill that evicts 1. Read 1 -> q=0x11 from memory.
- Write 0x9C to 9 into a clean invalid way -> valid the cycle after accept, hit=0, q=0x9C, no memory traffic.
- Dirty ways 0 and 2, then flush -> exactly 2 mem_wren pulses in 4 cycles with the correct tag/data, then a flush_done pulse. A second flush -> 0 mem_wren pulses, flush_done after 4 cycles. req and flush together -> only flush runs.
- resetn low during FILL -> ready=1, valid=0, mem_wren=0 immediately. After release, re-reading the address misses (hit=0).
